// File: rtl/viterbi_tb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_tb_scheduler
// Purpose  : Sequences the Viterbi traceback engine over a ring of survivor
//            memory banks, with a tail-terminated flush at frame end.
//            Optional BUSY watchdog enabled by VITERBI_TB_WATCHDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
module viterbi_tb_scheduler #(
    parameter int TB_LEN    = 128,
    parameter int ADDR_W    = 7,
    parameter int NUM_BANKS = 4,
    parameter int BANK_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acs_valid,
    input  logic              frame_last,
    output logic              acs_ready,
    output logic              wr_en,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              tb_start,
    output logic [BANK_W-1:0] tb_bank,
    output logic [BANK_W-1:0] tb_conv_bank,
    output logic [7:0]        tb_len,
    output logic              tb_flush,
    input  logic              tb_done,
    output logic              frame_done,
`ifdef VITERBI_TB_WATCHDOG_EN
    output logic              tb_error,
`endif
    output logic [BANK_W:0]   occupancy
);

    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(TB_LEN - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);
    localparam logic [BANK_W-1:0] C_BANK_ONE  = BANK_W'(1);
    localparam logic [BANK_W:0]   C_OCC_FULL  = (BANK_W+1)'(NUM_BANKS);
    localparam logic [BANK_W:0]   C_OCC_ONE   = (BANK_W+1)'(1);
    localparam logic [BANK_W:0]   C_OCC_TWO   = (BANK_W+1)'(2);
    localparam logic [7:0]        C_TB_LEN    = 8'(TB_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BANK_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [BANK_W-1:0]  r_rd_ptr;
    logic [BANK_W:0]    r_occ;
    logic               r_flushing;
    logic [BANK_W-1:0]  r_last_bank;
    logic [7:0]         r_last_fill;

    logic               w_accept;
    logic               w_close;
    logic               w_flush_bank;
    logic               w_eligible;
    logic               w_release;
    logic               w_wd_expire;

    assign w_accept     = acs_valid & acs_ready;
    assign w_close      = w_accept & (frame_last | (r_wr_addr == C_ADDR_LAST));
    assign w_flush_bank = r_flushing & (r_rd_ptr == r_last_bank);
    // Once the frame has ended, no successor bank will arrive to converge on
    assign w_eligible   = r_flushing ? (r_occ >= C_OCC_ONE) : (r_occ >= C_OCC_TWO);

`ifdef VITERBI_TB_WATCHDOG_EN
    logic [9:0] r_wd_cnt;
    logic       r_tb_error;

    assign w_wd_expire = (r_state == ST_BUSY) & (r_wd_cnt == 10'd1023);
    assign tb_error    = r_tb_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt   <= 10'd0;
            r_tb_error <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == ST_BUSY) ? r_wd_cnt + 10'd1 : 10'd0;
            if (w_wd_expire & ~tb_done) begin
                r_tb_error <= 1'b1;
            end
        end
    end
`else
    assign w_wd_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        tb_start    = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_eligible) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tb_start    = 1'b1;
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (tb_done | w_wd_expire) begin
                    w_release   = 1'b1;
                    w_state_nxt = w_flush_bank ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_wr_addr   <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_flushing  <= 1'b0;
            r_last_bank <= '0;
            r_last_fill <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_wr_addr <= w_close ? '0 : r_wr_addr + C_ADDR_ONE;
            end
            if (w_close) begin
                r_wr_ptr <= r_wr_ptr + C_BANK_ONE;
            end
            if (w_accept & frame_last) begin
                r_flushing  <= 1'b1;
                r_last_bank <= r_wr_ptr;
                r_last_fill <= 8'(r_wr_addr) + 8'd1;
            end

            if (w_release) begin
                r_rd_ptr <= r_rd_ptr + C_BANK_ONE;
            end

            // Close and release in the same cycle cancel out
            case ({w_close, w_release})
                2'b10:   r_occ <= r_occ + C_OCC_ONE;
                2'b01:   r_occ <= r_occ - C_OCC_ONE;
                default: r_occ <= r_occ;
            endcase

            if (r_state == ST_DONE) begin
                r_flushing <= 1'b0;
                r_wr_ptr   <= r_rd_ptr;
            end
        end
    end

    assign acs_ready    = (r_occ < C_OCC_FULL) & ~r_flushing;
    assign wr_en        = w_accept;
    assign wr_bank      = r_wr_ptr;
    assign wr_addr      = r_wr_addr;
    assign tb_bank      = r_rd_ptr;
    assign tb_conv_bank = r_rd_ptr + C_BANK_ONE;
    assign tb_flush     = w_flush_bank;
    assign tb_len       = w_flush_bank ? r_last_fill : C_TB_LEN;
    assign occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_tb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_tb_scheduler
// Purpose  : Scoreboard bench for viterbi_tb_scheduler with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_viterbi_tb_scheduler;
    localparam int TB_LEN    = 128;
    localparam int ADDR_W    = 7;
    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic acs_valid = 1'b0;
    logic frame_last = 1'b0;
    logic done_auto = 1'b0;
    logic done_man = 1'b0;
    wire logic tb_done = done_auto | done_man;

    logic              acs_ready, wr_en, tb_start, tb_flush, frame_done;
    logic [BANK_W-1:0] wr_bank, tb_bank, tb_conv_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        tb_len;
    logic [BANK_W:0]   occupancy;
`ifdef VITERBI_TB_WATCHDOG_EN
    logic              tb_error;
`endif

    viterbi_tb_scheduler #(
        .TB_LEN(TB_LEN), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)
    ) dut (
        .clk(clk), .reset(reset), .acs_valid(acs_valid), .frame_last(frame_last),
        .acs_ready(acs_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .tb_start(tb_start), .tb_bank(tb_bank), .tb_conv_bank(tb_conv_bank),
        .tb_len(tb_len), .tb_flush(tb_flush), .tb_done(tb_done),
        .frame_done(frame_done),
`ifdef VITERBI_TB_WATCHDOG_EN
        .tb_error(tb_error),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int bank; int conv; int len; bit flush; } cmd_t;
    typedef struct { int bank; int addr; } wr_t;
    cmd_t cmd_q[$];
    wr_t  wr_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int frames_exp = 0;
    int frames_seen = 0;
    int base_bank = 0;
    bit hold_done = 0;
    int done_min = 1;
    int done_max = 15;
    int last_flush_done_cyc = -100;
    int last_start_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Frame-level model: an n-symbol frame fills ceil(n/TB_LEN) consecutive
    // banks; every bank but the last decodes at full length, the last is a flush.
    task automatic expect_frame(input int n);
        int k;
        cmd_t c;
        k = (n + TB_LEN - 1) / TB_LEN;
        for (int i = 0; i < k; i++) begin
            c.bank  = (base_bank + i) % NUM_BANKS;
            c.conv  = (c.bank + 1) % NUM_BANKS;
            c.flush = (i == k - 1);
            c.len   = c.flush ? n - TB_LEN * (k - 1) : TB_LEN;
            cmd_q.push_back(c);
        end
        frames_exp++;
    endtask

    task automatic send_frame(input int n, input bit with_last, input int pct);
        int sent;
        int waited;
        wr_t w;
        sent = 0;
        waited = 0;
        while (sent < n) begin
            @(negedge clk);
            acs_valid  = ($urandom_range(99) < pct);
            frame_last = with_last && (sent == n - 1);
            #1;
            if (acs_valid && acs_ready) begin
                w.bank = (base_bank + sent / TB_LEN) % NUM_BANKS;
                w.addr = sent % TB_LEN;
                wr_q.push_back(w);
                sent++;
                waited = 0;
            end else begin
                waited++;
                if (waited > 4000) begin
                    check("accept_timeout", 0, 1);
                    break;
                end
            end
        end
        @(negedge clk);
        acs_valid  = 1'b0;
        frame_last = 1'b0;
        if (with_last) base_bank = (base_bank + (n + TB_LEN - 1) / TB_LEN) % NUM_BANKS;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (frames_seen < frames_exp && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("frame_complete_timeout", frames_seen, frames_exp);
        repeat (2) @(negedge clk);
    endtask

    // Write monitor
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            #2;
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_bank", int'(wr_bank), w.bank);
                    check("wr_addr", int'(wr_addr), w.addr);
                end
            end
        end
    end

    // Traceback command monitor and engine responder
    initial begin
        cmd_t c;
        bit   have;
        int   d;
        forever begin
            @(negedge clk);
            #1;
            if (tb_start) begin
                last_start_cyc = cyc;
                have = (cmd_q.size() != 0);
                if (!have) begin
                    check("tb_start_unexpected", 1, 0);
                end else begin
                    c = cmd_q.pop_front();
                    check("tb_bank", int'(tb_bank), c.bank);
                    check("tb_conv_bank", int'(tb_conv_bank), c.conv);
                    check("tb_len", int'(tb_len), c.len);
                    check("tb_flush", int'(tb_flush), int'(c.flush));
                end
                if (!hold_done) begin
                    d = $urandom_range(done_max, done_min);
                    repeat (d) @(negedge clk);
                    if (have) check("tb_bank_held", int'(tb_bank), c.bank);
                    done_auto = 1'b1;
                    if (have && c.flush) last_flush_done_cyc = cyc;
                    @(negedge clk);
                    done_auto = 1'b0;
                end
            end
        end
    end

    // frame_done monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (frame_done) begin
                frames_seen++;
                check("frame_done_timing", cyc, last_flush_done_cyc + 1);
            end
        end
    end

    initial begin
        int lens[3];
        int t;
        lens[0] = 128;
        lens[1] = 129;
        lens[2] = 384;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_acs_ready", int'(acs_ready), 1);
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_tb_start", int'(tb_start), 0);
        check("rst_tb_flush", int'(tb_flush), 0);
        check("rst_tb_len", int'(tb_len), TB_LEN);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_tb_bank", int'(tb_bank), 0);
        check("rst_wr_addr", int'(wr_addr), 0);

        done_min = 10;
        done_max = 10;
        expect_frame(512); send_frame(512, 1'b1, 100); wait_idle();
        expect_frame(200); send_frame(200, 1'b1, 100); wait_idle();
        expect_frame(1);   send_frame(1, 1'b1, 100);   wait_idle();

        done_min = 1;
        done_max = 15;
        foreach (lens[i]) begin
            expect_frame(lens[i]); send_frame(lens[i], 1'b1, 90); wait_idle();
        end
        for (int i = 0; i < 5; i++) begin
            t = $urandom_range(600, 1);
            expect_frame(t);
            send_frame(t, 1'b1, $urandom_range(100, 50));
            wait_idle();
        end

        // Back-pressure: no tb_done, ring fills to NUM_BANKS
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base_bank = 0;
        hold_done = 1;
        expect_frame(TB_LEN * 3);
        cmd_q.pop_back();
        frames_exp--;
        send_frame(TB_LEN * NUM_BANKS, 1'b0, 100);
        #1;
        check("full_acs_ready", int'(acs_ready), 0);
        check("full_occupancy", int'(occupancy), NUM_BANKS);
        repeat (10) begin
            @(negedge clk);
            acs_valid = 1'b1;
        end
        @(negedge clk);
        acs_valid = 1'b0;
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        #1;
        check("release_acs_ready", int'(acs_ready), 1);
        check("release_occupancy", int'(occupancy), NUM_BANKS - 1);
        repeat (4) @(negedge clk);
        check("bank1_issued", cmd_q.size(), 0);

        // Reset while BUSY, then a stale tb_done
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("postrst_tb_bank", int'(tb_bank), 0);
        check("postrst_occupancy", int'(occupancy), 0);
        check("postrst_acs_ready", int'(acs_ready), 1);

`ifdef VITERBI_TB_WATCHDOG_EN
        expect_frame(1);
        send_frame(1, 1'b1, 100);
        t = 0;
        while (cmd_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        last_flush_done_cyc = last_start_cyc + 1024;
        wait_idle();
        #1;
        check("wd_tb_error", int'(tb_error), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("wd_tb_error_clear", int'(tb_error), 0);
`endif

        hold_done = 0;
        check("frames_total", frames_seen, frames_exp);
        check("cmd_q_empty", cmd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/viterbi_tb_scheduler.md
# viterbi_tb_scheduler

Bank scheduler for the Wi-Fi PHY Viterbi survivor memory. ACS survivor vectors are written into a ring of fixed-length banks. The block sequences the traceback engine over those banks: each closed bank is decoded once its successor bank can serve as the convergence bank. At frame end, the block flushes the remaining banks in a tail-terminated traceback. It sits between the ACS unit, the survivor RAM write port and the traceback engine.

## Interface
- TB_LEN, 128: entries per bank (traceback length)
- ADDR_W, 7: log2(TB_LEN)
- NUM_BANKS, 4: banks in the ring (power of two)
- BANK_W, 2: log2(NUM_BANKS)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- acs_valid  in  1  ACS offers one survivor vector this cycle
- frame_last  in  1  qualifies acs_valid: last symbol of frame
- acs_ready  out  1  write accepted when acs_valid & acs_ready
- wr_en  out  1  survivor RAM write strobe, combinational acs_valid & acs_ready
- wr_bank  out  BANK_W  bank being written
- wr_addr  out  ADDR_W  entry within wr_bank
- tb_start  out  1  one-cycle traceback command
- tb_bank  out  BANK_W  bank to decode, held from tb_start until tb_done
- tb_conv_bank  out  BANK_W  convergence bank (tb_bank+1 mod NUM_BANKS)
- tb_len  out  8  valid entries in tb_bank, 1..TB_LEN
- tb_flush  out  1  no convergence pass; start from state 0
- tb_done  in  1  traceback engine finished tb_bank (pulse)
- frame_done  out  1  one-cycle pulse after final flush traceback completes
- occupancy  out  BANK_W+1  closed, undecoded banks

## Operation
- Registers:
  - wr_ptr, wr_addr: write pointer and entry address
  - rd_ptr: next bank to decode
  - occupancy: closed, undecoded banks
  - flushing: frame-end flush in progress
  - last_bank, last_fill: bank and fill count of the final (partial) bank
- Reset values:
  - All of the above registers are 0.
  - tb_start, tb_flush and frame_done are 0. tb_len is TB_LEN.
  - State is IDLE.
  - acs_ready = 1 after reset.
- Write side:
  - acs_ready = (occupancy < NUM_BANKS) & !flushing.
  - On an accepted write, wr_addr increments.
  - When wr_addr = TB_LEN-1 is accepted, or frame_last is accepted: the bank closes, wr_ptr increments mod NUM_BANKS, wr_addr returns to 0, and occupancy increments.
  - When frame_last is accepted, also: flushing=1, last_bank=wr_ptr, last_fill=wr_addr+1.
- FSM states: IDLE, ISSUE, BUSY, DONE.
  - IDLE -> ISSUE when a decode is eligible:
    - Normal: occupancy >= 2.
    - Flushing: occupancy >= 1.
  - ISSUE: drives tb_start=1 for one cycle with tb_bank=rd_ptr and tb_conv_bank=rd_ptr+1. Then goes to BUSY.
    - If flushing and rd_ptr == last_bank: tb_flush=1 and tb_len=last_fill.
    - Otherwise: tb_flush=0 and tb_len=TB_LEN.
  - BUSY: on tb_done, rd_ptr increments and occupancy decrements.
    - Goes to DONE if the bank just decoded was the flush bank.
    - Otherwise goes to IDLE.
  - DONE: frame_done=1 for one cycle. Clears flushing, resets wr_ptr=rd_ptr, then goes to IDLE.
- Simultaneous events:
  - A bank close and a tb_done release in the same cycle leave occupancy unchanged.
  - tb_done outside BUSY is ignored.
  - acs_valid while acs_ready=0 is ignored; no RAM write occurs.
- Boundary cases:
  - frame_last on entry TB_LEN-1 closes the bank once; last_fill = TB_LEN (tb_len=128).
  - A one-symbol frame gives tb_len=1 with tb_flush=1.
- Reset mid-operation: all state is discarded. A late tb_done after reset is ignored.

## Timing
- acs_ready, occupancy and the tb_* outputs are registered or decoded from registers; no input-to-output combinational path exists except wr_en.
- tb_start rises 1 cycle after the eligibility condition becomes true: IDLE -> ISSUE takes one edge, and tb_start is asserted during ISSUE.
- The earliest next tb_start is 2 cycles after tb_done (BUSY -> IDLE -> ISSUE).
- frame_done is asserted 1 cycle after the final tb_done.
- acs_ready deasserts the cycle after the write that makes occupancy = NUM_BANKS. It reasserts the cycle after the tb_done that releases a bank.

## Configuration
- VITERBI_TB_WATCHDOG_EN defined:
  - A 10-bit counter runs in BUSY.
  - If it reaches 1023 without tb_done, the block forces the release: rd_ptr++, occupancy--, next state as on tb_done.
  - It also sets the sticky output tb_error (1 bit). tb_error clears only on reset.
- Without the macro: no counter and no tb_error port; BUSY waits indefinitely.

## Test plan
- Continuous acs_valid, 512 symbols, frame_last on symbol 511, tb_done 10 cycles after each tb_start:
  - Three tb_start pulses with tb_bank 0,1,2 and tb_len=128, tb_flush=0.
  - Then tb_bank=3, tb_flush=1, tb_len=128.
  - One frame_done.
- Frame of 200 symbols:
  - Bank 0 decoded with tb_conv_bank=1.
  - Bank 1 decoded with tb_flush=1, tb_len=72.
- Never assert tb_done, stream 600 symbols:
  - After bank 0 closes, occupancy climbs to 4 and acs_ready drops after symbol 512 is accepted.
  - A single tb_done raises acs_ready the next cycle.
- One-symbol frame (acs_valid & frame_last once): tb_start with tb_bank=0, tb_len=1, tb_flush=1; frame_done 1 cycle after tb_done.
- Assert reset while BUSY, then pulse tb_done: no rd_ptr change, occupancy=0, acs_ready=1, no frame_done.
- With VITERBI_TB_WATCHDOG_EN, hold tb_done low in BUSY: forced release after 1023 cycles; tb_error=1 until reset.
